// File: rtl/eb_ram_pkg.sv
// Shared helpers for the byte-enabled dual-port RAM: lane count, byte parity, legal read latencies.
package eb_ram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int lane_count(input int d_width);
        return d_width / 8;
    endfunction

    // Even parity: the stored bit makes the total count of ones across byte+bit even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/eb_ram_bytelane_merge.sv
// Combinational lane merge: lanes with be set take new_word, the rest keep old_word.
module eb_ram_bytelane_merge #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic [LANES*LANE_W-1:0] old_word,
    input  logic [LANES*LANE_W-1:0] new_word,
    input  logic [LANES-1:0]        be,
    output logic [LANES*LANE_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/dual_port_pipelined_be_ram.sv
// Simple dual-port RAM with byte enables, 1/2-stage enabled read pipeline and optional bypass.
// Define DPRAM_PARITY_EN to add per-byte parity storage and the parity_err output.
module dual_port_pipelined_be_ram
    import eb_ram_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 11,
    parameter int RD_LAT  = 1,
    parameter int BYPASS  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enableout,
    input  logic                           re,
    input  logic                           we,
    input  logic [lane_count(D_WIDTH)-1:0] be,
    input  logic [D_WIDTH-1:0]             data,
    input  logic [A_WIDTH-1:0]             write_addr,
    input  logic [A_WIDTH-1:0]             read_addr,
    output logic [D_WIDTH-1:0]             q,
    output logic                           q_valid
`ifdef DPRAM_PARITY_EN
    ,
    output logic                           parity_err
`endif
);

    localparam int NB    = lane_count(D_WIDTH);
    localparam int DEPTH = 2 ** A_WIDTH;
`ifdef DPRAM_PARITY_EN
    localparam int MW    = D_WIDTH + NB;
`else
    localparam int MW    = D_WIDTH;
`endif

    if (RD_LAT != RD_LAT_MIN && RD_LAT != RD_LAT_MAX) begin : g_bad_lat
        $error("dual_port_pipelined_be_ram: RD_LAT must be 1 or 2");
    end

    (* ramstyle = "block" *) logic [MW-1:0] ram [DEPTH];

    logic [MW-1:0]      wr_old;
    logic [MW-1:0]      wr_entry;
    logic [MW-1:0]      rd_entry;
    logic [D_WIDTH-1:0] wr_merged;
    logic               collide;
    logic [D_WIDTH-1:0] s1_data;
    logic               s1_valid;
    logic               rd_perr;
    logic               s1_perr;

    assign wr_old = ram[write_addr];

    eb_ram_bytelane_merge #(.LANES(NB), .LANE_W(8)) u_merge (
        .old_word (wr_old[D_WIDTH-1:0]),
        .new_word (data),
        .be       (be),
        .merged   (wr_merged)
    );

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] new_par;
    logic [NB-1:0] wr_par;

    always_comb begin
        for (int i = 0; i < NB; i++) new_par[i] = byte_parity(data[8*i +: 8]);
    end

    eb_ram_bytelane_merge #(.LANES(NB), .LANE_W(1)) u_par_merge (
        .old_word (wr_old[MW-1:D_WIDTH]),
        .new_word (new_par),
        .be       (be),
        .merged   (wr_par)
    );

    assign wr_entry = {wr_par, wr_merged};

    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rd_perr = rd_perr | (rd_entry[D_WIDTH+i] ^ byte_parity(rd_entry[8*i +: 8]));
        end
    end
`else
    assign wr_entry = wr_merged;
    assign rd_perr  = 1'b0;
`endif

    // On a collision the write-path merge already is the post-write word, so it doubles as the bypass.
    assign collide  = (BYPASS != 0) && we && (write_addr == read_addr);
    assign rd_entry = collide ? wr_entry : ram[read_addr];

    always_ff @(posedge clk) begin
        if (we) ram[write_addr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_perr  <= 1'b0;
        end else if (enableout) begin
            s1_data  <= rd_entry[D_WIDTH-1:0];
            s1_valid <= re;
            s1_perr  <= re & rd_perr;
        end
    end

    logic q_perr;

    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
        always_ff @(posedge clk) begin
            if (rst) begin
                q       <= '0;
                q_valid <= 1'b0;
                q_perr  <= 1'b0;
            end else if (enableout) begin
                q       <= s1_data;
                q_valid <= s1_valid;
                q_perr  <= s1_perr;
            end
        end
    end else begin : g_lat1
        assign q       = s1_data;
        assign q_valid = s1_valid;
        assign q_perr  = s1_perr;
    end

`ifdef DPRAM_PARITY_EN
    assign parity_err = q_perr;
`endif

endmodule

// File: tb/tb_dual_port_pipelined_be_ram.sv
// Scoreboard bench: two instances (RD_LAT=2/BYPASS=0 and RD_LAT=1/BYPASS=1) share one stimulus.
module tb_dual_port_pipelined_be_ram;

    typedef struct packed {
        logic [31:0] d;
        logic        perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enableout, re, we;
    logic [3:0]  be;
    logic [31:0] data;
    logic [10:0] write_addr, read_addr;
    logic [31:0] qa, qb;
    logic        va, vb, pa, pb;

    exp_t        sq_a[$];
    exp_t        sq_b[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        last_en, last_rst;
    logic [31:0] cur_q[2];
    logic        cur_v[2];

    always #5 clk = ~clk;

    dual_port_pipelined_be_ram #(.D_WIDTH(32), .A_WIDTH(11), .RD_LAT(2), .BYPASS(0)) u_a (
        .clk(clk), .rst(rst), .enableout(enableout), .re(re), .we(we), .be(be), .data(data),
        .write_addr(write_addr), .read_addr(read_addr), .q(qa), .q_valid(va)
`ifdef DPRAM_PARITY_EN
        , .parity_err(pa)
`endif
    );

    dual_port_pipelined_be_ram #(.D_WIDTH(32), .A_WIDTH(11), .RD_LAT(1), .BYPASS(1)) u_b (
        .clk(clk), .rst(rst), .enableout(enableout), .re(re), .we(we), .be(be), .data(data),
        .write_addr(write_addr), .read_addr(read_addr), .q(qb), .q_valid(vb)
`ifdef DPRAM_PARITY_EN
        , .parity_err(pb)
`endif
    );

`ifndef DPRAM_PARITY_EN
    assign pa = 1'b0;
    assign pb = 1'b0;
`endif

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input logic [31:0] qv, input logic vv, input logic pe);
        exp_t e;
        if (last_rst) begin
            chk("reset_q", k, qv, 32'h0);
            chk("reset_valid", k, {31'b0, vv}, 32'h0);
            chk("reset_perr", k, {31'b0, pe}, 32'h0);
            cur_v[k] = 1'b0;
        end else if (last_en) begin
            if (vv) begin
                if ((k == 0 ? sq_a.size() : sq_b.size()) == 0) begin
                    chk("spurious_valid", k, {31'b0, vv}, 32'h0);
                end else begin
                    e = (k == 0) ? sq_a.pop_front() : sq_b.pop_front();
                    chk("read_data", k, qv, e.d);
                    chk("parity_err", k, {31'b0, pe}, {31'b0, e.perr});
                    cur_q[k] = e.d;
                    cur_v[k] = 1'b1;
                end
            end else begin
                cur_v[k] = 1'b0;
            end
        end else begin
            chk("stall_hold_valid", k, {31'b0, vv}, {31'b0, cur_v[k]});
            if (cur_v[k]) chk("stall_hold_q", k, qv, cur_q[k]);
        end
    endtask

    always @(posedge clk) begin
        last_en  <= enableout & ~rst;
        last_rst <= rst;
    end

    always @(negedge clk) begin
        mon(0, qa, va, pa);
        mon(1, qb, vb, pb);
    end

    task automatic cyc(input logic en, input logic r, input int ra, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input int wa, input logic [31:0] ea, input logic [31:0] eb,
                       input logic ep);
        exp_t x;
        enableout  = en;
        re         = r;
        read_addr  = 11'(ra);
        we         = w;
        be         = b;
        data       = d;
        write_addr = 11'(wa);
        if (en && r && !rst) begin
            x.d = ea; x.perr = ep; sq_a.push_back(x);
            x.d = eb; sq_b.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [3:0] b, input logic [31:0] d);
        cyc(1'b1, 1'b0, 0, 1'b1, b, d, a, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rd(input int a, input logic [31:0] e, input logic ep);
        cyc(1'b1, 1'b1, a, 1'b0, 4'h0, 32'h0, 0, e, e, ep);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 1'b0, 4'h0, 32'h0, 0, 32'h0, 32'h0, 1'b0);
    endtask

    logic [31:0] stored[4];

    initial begin
        cur_v[0] = 1'b0; cur_v[1] = 1'b0;
        cur_q[0] = 32'h0; cur_q[1] = 32'h0;
        stored[0] = 32'h0101_0101; stored[1] = 32'h0202_0202;
        stored[2] = 32'h0303_0303; stored[3] = 32'hDEAD_BEEF;
        rst = 1'b1; enableout = 1'b1; re = 1'b1; we = 1'b0; be = 4'h0; data = 32'h0;
        write_addr = 11'h0; read_addr = 11'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // byte enables
        wr(5, 4'b1111, 32'hAABB_CCDD);
        wr(5, 4'b0101, 32'h1122_3344);
        rd(5, 32'hAA22_CC44, 1'b0);
        for (int i = 0; i < 4; i++) wr(i, 4'b1111, stored[i]);
        wr(7, 4'b1111, 32'h0);
        idle(2);

        // stall: enableout toggling, rejected requests in the stalled cycles
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, i, 1'b0, 4'h0, 32'h0, 0, stored[i], stored[i], 1'b0);
            cyc(1'b0, 1'b1, (i + 1) % 4, 1'b0, 4'h0, 32'h0, 0, 32'h0, 32'h0, 1'b0);
        end
        idle(3);

        // collisions: full and partial byte enables
        cyc(1'b1, 1'b1, 7, 1'b1, 4'b1111, 32'h1234_5678, 7, 32'h0, 32'h1234_5678, 1'b0);
        cyc(1'b1, 1'b1, 7, 1'b1, 4'b0011, 32'hAAAA_BBBB, 7, 32'h1234_5678, 32'h1234_BBBB, 1'b0);
        rd(7, 32'h1234_BBBB, 1'b0);
        idle(3);

        // re=0 filtering
        for (int i = 0; i < 6; i++)
            cyc(1'b1, (i % 2) == 0, i % 4, 1'b0, 4'h0, 32'h0, 0, stored[i % 4], stored[i % 4], 1'b0);
        idle(3);

        // reset one cycle after a read; a write during reset still commits
        rd(3, 32'hDEAD_BEEF, 1'b0);
        rst = 1'b1;
        wr(12, 4'b1111, 32'hCAFE_F00D);
        rst = 1'b0;
        sq_a.delete();
        sq_b.delete();
        rd(3, 32'hDEAD_BEEF, 1'b0);
        rd(12, 32'hCAFE_F00D, 1'b0);
        idle(3);

`ifdef DPRAM_PARITY_EN
        wr(9, 4'b1111, 32'h0F0F_0F0F);
        wr(10, 4'b1111, 32'h1111_1111);
        idle(1);
        u_a.ram[9][0] = ~u_a.ram[9][0];
        u_b.ram[9][0] = ~u_b.ram[9][0];
        rd(9, 32'h0F0F_0F0E, 1'b1);
        rd(10, 32'h1111_1111, 1'b0);
        idle(3);
`endif

        idle(2);
        chk("leftover_a", 0, 32'(sq_a.size()), 32'h0);
        chk("leftover_b", 1, 32'(sq_b.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
